ex_mem_flag_stage: RTL and testbench
====================================

EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports, listed as name, direction, width, meaning:
 - clk  in  1  clock; all state changes on its rising edge.
 - rst_n  in  1  asynchronous, active-low reset.
 - ex_valid  in  1  EX holds a real instruction.
 - alu_out  in  16  ALU result.
 - alu_flags  in  3  ALU flags: [2]=V, [1]=Z, [0]=N.
 - alu_op  in  4  ALU opcode of the EX instruction.
 - alu_err  in  1  ALU undefined-op indication.
 - st_data_in  in  16  store data.
 - rd_in  in  4  destination register.
 - reg_wr_in, mem_rd_in, mem_wr_in  in  1 each  control bits.
 - stall  in  1  MEM busy; hold the stage.
 - flush  in  1  kill the EX instruction.
 - br_valid  in  1  ID presents a conditional branch.
 - br_cond  in  3  branch condition code.
 - mem_valid  out  1  MEM-stage valid.
 - mem_result  out  16  registered ALU result / address.
 - mem_st_data  out  16  registered store data.
 - mem_rd  out  4  registered destination register.
 - mem_reg_wr, mem_mem_rd, mem_mem_wr  out  1 each  registered control bits.
 - flags_q  out  3  architectural flag register {V,Z,N}.
 - br_taken  out  1  branch decision (combinational).
 - err_sticky  out  1  latched ALU error.

Function
REQ-003 Capture condition: cap = ex_valid & ~stall & ~flush.
REQ-004 When cap=1, on the clock edge: mem_valid<=1 and every mem_* register takes its *_in / alu_out value. The stage has one cycle of latency.
REQ-005 When stall=1, all registers hold, including flags_q and mem_valid. Stall has priority over flush.
REQ-006 When stall=0 and (flush=1 or ex_valid=0), on the clock edge: mem_valid<=0 and mem_reg_wr, mem_mem_rd and mem_mem_wr <=0. The data registers hold.
REQ-007 Flag update on cap=1, by alu_op:
 - 000x (ADD/SUB): flags_q <= alu_flags (all three bits).
 - 0010 (XOR) and 010x (shifts): only Z <= alu_flags[1].
 - All other opcodes: no flag change.
REQ-008 Flags SHALL NOT change on stalled, flushed or invalid cycles.
REQ-009 The flag source fsel is defined in REQ-016. br_taken = br_valid & cond(fsel), where cond is:
 - 000: NE, Z=0.
 - 001: EQ, Z=1.
 - 010: GT, Z=0 & N=0.
 - 011: LT, N=1.
 - 100: GE, Z=1 | (Z=0 & N=0).
 - 101: LE, N=1 | Z=1.
 - 110: OV, V=1.
 - 111: unconditional.
REQ-010 br_taken SHALL be 0 whenever br_valid=0.
REQ-011 err_sticky is set on the edge where ex_valid=1, alu_err=1 and flush=0, even during a stall. It clears only on reset.
REQ-012 Passing through this stage SHALL NOT alter data widths or values. mem_result SHALL equal alu_out bit-exactly.

Reset
REQ-013 While rst_n=0, independent of clk:
 - mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, err_sticky = 0.
 - mem_result, mem_st_data = 16'h0000; mem_rd = 4'h0.
 - flags_q = 3'b000.
REQ-014 When rst_n rises, the first capture occurs on the next rising clk edge where cap=1.
REQ-015 Reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-016 Macro FLAG_FWD_EN:
 - Defined: fsel is the flag value that would be written this cycle (REQ-007 applied to flags_q) whenever cap=1, otherwise flags_q. A branch in ID directly behind a flag-setting instruction resolves correctly with no bubble.
 - Undefined: fsel = flags_q always. The hazard unit SHALL insert one stall cycle after any flag-setting instruction.

Verification
REQ-017 Reset at flags_q=3'b111 and mem_valid=1: assert rst_n=0 with no clk edge -> all outputs reach their reset values immediately.
REQ-018 SUB 5-5 (alu_op=0001, alu_out=0, alu_flags=3'b010, cap=1) -> next cycle flags_q=3'b010, mem_result=0. With br_cond=001 and br_valid=1, br_taken=1.
REQ-019 flags_q=3'b001, then XOR with alu_flags=3'b110 -> flags_q=3'b011 (V and N unchanged).
REQ-020 stall=1 for 3 cycles with varying EX inputs -> mem_* and flags_q constant. Stall and flush together -> still held. After stall drops with flush=1 -> mem_valid=0.
REQ-021 With FLAG_FWD_EN: ADD producing N (alu_flags=3'b001) in EX, br_cond=011 in the same cycle -> br_taken=1. Without the macro -> br_taken=0 that cycle and 1 the next.
REQ-022 alu_err=1 with ex_valid=1 during a stall -> err_sticky=1 and it stays 1 until rst_n=0.

Source files
------------

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX/MEM pipeline register with flag register, branch resolve and sticky ALU error; FLAG_FWD_EN forwards next flags to branch
module ex_mem_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flags,
  input  logic [3:0]  alu_op,
  input  logic        alu_err,
  input  logic [15:0] st_data_in,
  input  logic [3:0]  rd_in,
  input  logic        reg_wr_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  output logic        mem_valid,
  output logic [15:0] mem_result,
  output logic [15:0] mem_st_data,
  output logic [3:0]  mem_rd,
  output logic        mem_reg_wr,
  output logic        mem_mem_rd,
  output logic        mem_mem_wr,
  output logic [2:0]  flags_q,
  output logic        br_taken,
  output logic        err_sticky
);
  logic       cap, full_upd, z_upd, c;
  logic [2:0] flags_nx, fsel;
  always_comb begin
    cap      = ex_valid & ~stall & ~flush;
    full_upd = alu_op[3:1] == 3'b000;
    z_upd    = alu_op == 4'b0010 || alu_op[3:1] == 3'b010;
    flags_nx = full_upd ? alu_flags : z_upd ? {flags_q[2], alu_flags[1], flags_q[0]} : flags_q;
`ifdef FLAG_FWD_EN
    fsel     = cap ? flags_nx : flags_q;
`else
    fsel     = flags_q;
`endif
    c = br_cond == 3'd0 ? ~fsel[1] :
        br_cond == 3'd1 ? fsel[1] :
        br_cond == 3'd2 ? ~fsel[1] & ~fsel[0] :
        br_cond == 3'd3 ? fsel[0] :
        br_cond == 3'd4 ? fsel[1] | ~fsel[0] :
        br_cond == 3'd5 ? fsel[0] | fsel[1] :
        br_cond == 3'd6 ? fsel[2] : 1'b1;
    br_taken = br_valid & c;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_result  <= 16'h0000;
      mem_st_data <= 16'h0000;
      mem_rd      <= 4'h0;
      mem_reg_wr  <= 1'b0;
      mem_mem_rd  <= 1'b0;
      mem_mem_wr  <= 1'b0;
      flags_q     <= 3'b000;
      err_sticky  <= 1'b0;
    end else begin
      if (ex_valid & alu_err & ~flush) err_sticky <= 1'b1;
      if (!stall) begin
        mem_valid  <= cap;
        mem_reg_wr <= cap & reg_wr_in;
        mem_mem_rd <= cap & mem_rd_in;
        mem_mem_wr <= cap & mem_wr_in;
        if (cap) begin
          mem_result  <= alu_out;
          mem_st_data <= st_data_in;
          mem_rd      <= rd_in;
          flags_q     <= flags_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: table vectors, directed corner sequences and random stimulus against a reference model
module tb_ex_mem_flag_stage;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid, alu_err, reg_wr_in, mem_rd_in, mem_wr_in, stall, flush, br_valid;
  logic [15:0] alu_out, st_data_in;
  logic [2:0]  alu_flags, br_cond;
  logic [3:0]  alu_op, rd_in;
  logic        mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, br_taken, err_sticky;
  logic [15:0] mem_result, mem_st_data;
  logic [3:0]  mem_rd;
  logic [2:0]  flags_q;
  int tests = 0, failed = 0;
  bit fwd;
  bit          m_valid, m_rw, m_mr, m_mw, m_err;
  logic [15:0] m_result, m_st;
  logic [3:0]  m_rd;
  logic [2:0]  m_flags;
  logic [2:0]  sv_flags;
  logic [15:0] sv_result;

  ex_mem_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_out(alu_out), .alu_flags(alu_flags),
    .alu_op(alu_op), .alu_err(alu_err), .st_data_in(st_data_in), .rd_in(rd_in),
    .reg_wr_in(reg_wr_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .stall(stall),
    .flush(flush), .br_valid(br_valid), .br_cond(br_cond), .mem_valid(mem_valid),
    .mem_result(mem_result), .mem_st_data(mem_st_data), .mem_rd(mem_rd),
    .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .flags_q(flags_q), .br_taken(br_taken), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev, st, fl;
    logic [3:0]  op;
    logic [2:0]  af;
    logic [15:0] ao;
    logic        xv;
    logic [2:0]  xf;
    logic [15:0] xr;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags an instruction would leave behind, straight from the opcode table.
  function automatic logic [2:0] written_flags(input logic [3:0] op, input logic [2:0] f, input logic [2:0] old);
    case (op)
      4'd0, 4'd1:       return f;
      4'd2, 4'd4, 4'd5: return {old[2], f[1], old[0]};
      default:          return old;
    endcase
  endfunction

  function automatic bit cond_true(input logic [2:0] cc, input logic [2:0] f);
    bit v = f[2], z = f[1], n = f[0];
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_br();
    bit cap = ex_valid && !stall && !flush;
    logic [2:0] f = (fwd && cap) ? written_flags(alu_op, alu_flags, m_flags) : m_flags;
    return br_valid && cond_true(br_cond, f);
  endfunction

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_err} = '0;
    m_result = 0; m_st = 0; m_rd = 0; m_flags = 0;
  endtask

  task automatic model_edge();
    if (ex_valid && alu_err && !flush) m_err = 1;
    if (!stall) begin
      if (ex_valid && !flush) begin
        m_valid = 1; m_result = alu_out; m_st = st_data_in; m_rd = rd_in;
        m_rw = reg_wr_in; m_mr = mem_rd_in; m_mw = mem_wr_in;
        m_flags = written_flags(alu_op, alu_flags, m_flags);
      end else begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".mem_valid"}, mem_valid, m_valid);
    chk({tag, ".mem_result"}, mem_result, m_result);
    chk({tag, ".mem_st_data"}, mem_st_data, m_st);
    chk({tag, ".mem_rd"}, mem_rd, m_rd);
    chk({tag, ".ctrl"}, {mem_reg_wr, mem_mem_rd, mem_mem_wr}, {m_rw, m_mr, m_mw});
    chk({tag, ".flags_q"}, flags_q, m_flags);
    chk({tag, ".err_sticky"}, err_sticky, m_err);
  endtask

  task automatic rnd_inputs();
    ex_valid = $urandom_range(3) != 0; alu_out = 16'($urandom); alu_flags = 3'($urandom);
    alu_op = 4'($urandom); alu_err = $urandom_range(15) == 0; st_data_in = 16'($urandom);
    rd_in = 4'($urandom); reg_wr_in = 1'($urandom); mem_rd_in = 1'($urandom);
    mem_wr_in = 1'($urandom); stall = $urandom_range(3) == 0; flush = $urandom_range(6) == 0;
    br_valid = 1'($urandom); br_cond = 3'($urandom);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle(input string tag);
    #1 chk({tag, ".br_taken"}, br_taken, model_br());
    @(posedge clk);
    model_edge();
    #1 compare_all(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1 model_reset();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_ex(input logic ev, input logic [3:0] op, input logic [2:0] af, input logic [15:0] ao);
    rnd_inputs();
    ex_valid = ev; alu_op = op; alu_flags = af; alu_out = ao;
    stall = 0; flush = 0; alu_err = 0; br_valid = 0;
  endtask

  initial begin
`ifdef FLAG_FWD_EN
    fwd = 1;
`else
    fwd = 0;
`endif
    rnd_inputs();
    model_reset();
    #1 compare_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;

    tbl[0]  = '{1, 0, 0, 4'b0001, 3'b010, 16'h0000, 1, 3'b010, 16'h0000};
    tbl[1]  = '{1, 0, 0, 4'b0000, 3'b001, 16'h1234, 1, 3'b001, 16'h1234};
    tbl[2]  = '{1, 0, 0, 4'b0010, 3'b110, 16'h00ff, 1, 3'b011, 16'h00ff};
    tbl[3]  = '{1, 0, 0, 4'b0100, 3'b000, 16'h0f0f, 1, 3'b001, 16'h0f0f};
    tbl[4]  = '{1, 0, 0, 4'b0101, 3'b010, 16'haaaa, 1, 3'b011, 16'haaaa};
    tbl[5]  = '{1, 0, 0, 4'b0011, 3'b100, 16'h5555, 1, 3'b011, 16'h5555};
    tbl[6]  = '{1, 0, 0, 4'b1111, 3'b111, 16'h7777, 1, 3'b011, 16'h7777};
    tbl[7]  = '{1, 1, 0, 4'b0000, 3'b111, 16'h1111, 1, 3'b011, 16'h7777};
    tbl[8]  = '{1, 0, 1, 4'b0000, 3'b111, 16'h2222, 0, 3'b011, 16'h7777};
    tbl[9]  = '{0, 0, 0, 4'b0000, 3'b100, 16'h3333, 0, 3'b011, 16'h7777};
    tbl[10] = '{1, 0, 0, 4'b0001, 3'b100, 16'hffff, 1, 3'b100, 16'hffff};
    tbl[11] = '{1, 1, 1, 4'b0000, 3'b010, 16'h4444, 1, 3'b100, 16'hffff};
    for (int i = 0; i < 12; i++) begin
      rnd_inputs();
      ex_valid = tbl[i].ev; stall = tbl[i].st; flush = tbl[i].fl;
      alu_op = tbl[i].op; alu_flags = tbl[i].af; alu_out = tbl[i].ao;
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.valid", i), mem_valid, tbl[i].xv);
      chk($sformatf("tbl%0d.flags", i), flags_q, tbl[i].xf);
      chk($sformatf("tbl%0d.result", i), mem_result, tbl[i].xr);
    end

    // SUB 5-5 then BEQ
    set_ex(1, 4'b0001, 3'b010, 16'h0000);
    cycle("sub");
    chk("sub.flags", flags_q, 3'b010);
    chk("sub.result", mem_result, 16'h0000);
    set_ex(0, 4'b0000, 3'b000, 16'h0);
    br_valid = 1; br_cond = 3'b001;
    #1 chk("beq.taken", br_taken, 1);
    br_valid = 0;
    #1 chk("beq.nobrv", br_taken, 0);
    @(negedge clk);

    // Flag hazard: ADD sets N, BLT in the same cycle
    set_ex(1, 4'b0000, 3'b000, 16'h0001);
    cycle("clrflags");
    set_ex(1, 4'b0000, 3'b001, 16'h8000);
    br_valid = 1; br_cond = 3'b011;
    #1 chk("blt.same", br_taken, fwd ? 1 : 0);
    cycle("blt_add");
    set_ex(0, 4'b0000, 3'b000, 16'h0);
    br_valid = 1; br_cond = 3'b011;
    #1 chk("blt.next", br_taken, 1);
    cycle("blt_next");

    // Three stalled cycles with changing EX, then stall+flush, then flush alone
    set_ex(1, 4'b0000, 3'b111, 16'hbeef);
    cycle("prestall");
    sv_flags = flags_q; sv_result = mem_result;
    for (int i = 0; i < 4; i++) begin
      rnd_inputs();
      stall = 1; flush = i == 3; ex_valid = 1; alu_op = 4'b0000;
      cycle($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.flags", i), flags_q, sv_flags);
      chk($sformatf("stall%0d.result", i), mem_result, sv_result);
      chk($sformatf("stall%0d.valid", i), mem_valid, 1);
    end
    rnd_inputs();
    stall = 0; flush = 1; ex_valid = 1;
    cycle("unstall_flush");
    chk("unstall_flush.valid", mem_valid, 0);
    chk("unstall_flush.flags", flags_q, sv_flags);

    // Reset with flags 111 and valid 1, no clock edge
    set_ex(1, 4'b0000, 3'b111, 16'hcafe);
    reg_wr_in = 1; mem_rd_in = 1; mem_wr_in = 1;
    cycle("preset");
    chk("preset.flags", flags_q, 3'b111);
    async_reset("async_rst");
    chk("async_rst.all", {mem_valid, mem_result, mem_st_data, mem_rd, mem_reg_wr, mem_mem_rd, mem_mem_wr, flags_q, err_sticky}, 0);

    // ALU error during stall is still latched and sticks
    set_ex(1, 4'b0000, 3'b000, 16'h0);
    stall = 1; alu_err = 1;
    cycle("err");
    chk("err.sticky", err_sticky, 1);
    for (int i = 0; i < 4; i++) begin
      rnd_inputs();
      alu_err = 0;
      cycle("err_hold");
    end
    chk("err.hold", err_sticky, 1);
    async_reset("err_rst");
    chk("err_rst.sticky", err_sticky, 0);

    for (int i = 0; i < 500; i++) begin
      rnd_inputs();
      if ($urandom_range(60) == 0) async_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
